por_rst_seq: RTL and testbench

Reset-release sequencer downstream of the POR one-shot. After the POR pulse completes, it deasserts N domain resets one at a time, inserting a programmable gap before each release. Each domain must return an acknowledge before the next one is released; an acknowledge timeout latches an error. Loss of filtered power-up immediately reasserts every domain reset.

---
 rtl/por_rst_seq.sv | 159 +++++++++++++++
 tb/tb_por_rst_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/por_rst_seq.sv
// Reset-release sequencer: after the POR one-shot completes, releases N_DOM
// active-low domain resets in ascending order, each gated on the previous domain's acknowledge.
module por_rst_seq #(
  parameter int N_DOM  = 4,
  parameter int GAP_W  = 8,
  parameter int ACK_TO = 255
) (
  input  logic             osc_ck,
  input  logic             rst,
  input  logic             pwup_filt,
  input  logic             por_timed_out,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [N_DOM-1:0] dom_ack,
  input  logic             err_clr,
  output logic [N_DOM-1:0] dom_rstb,
  output logic             seq_busy,
  output logic             seq_done,
  output logic             ack_err,
  output logic [2:0]       err_dom,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GAP  = 3'd1,
    S_ACK  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [15:0] ACK_LAST = 16'(ACK_TO - 1);
  localparam logic [2:0]  IDX_LAST = 3'(N_DOM - 1);

  state_t             state_q;
  logic [2:0]         idx_q;
  logic [15:0]        cnt_q;
  logic [GAP_W-1:0]   gap_q;
  logic [N_DOM-1:0]   dom_rstb_q;
  logic               seq_busy_q;
  logic               seq_done_q;
  logic               ack_err_q;
  logic [2:0]         err_dom_q;
  logic [N_DOM-1:0]   ack_s1_q;
  logic [N_DOM-1:0]   ack_s2_q;

  logic [N_DOM-1:0]   idx_onehot;
  logic               ack_cur;
  logic [15:0]        gap_ext;

  assign gap_ext = 16'(gap_q);

  always_ff @(posedge osc_ck or posedge rst) begin
    if (rst) begin
      ack_s1_q <= '0;
      ack_s2_q <= '0;
    end else begin
      ack_s1_q <= dom_ack;
      ack_s2_q <= ack_s1_q;
    end
  end

  always_comb begin
    idx_onehot = '0;
    ack_cur    = 1'b0;
    for (int k = 0; k < N_DOM; k++) begin
      if (idx_q == 3'(k)) begin
        idx_onehot[k] = 1'b1;
        ack_cur       = ack_s2_q[k];
      end
    end
  end

  // Release/ack handshake: a rising dom_rstb[i] is the request and the
  // synchronized dom_ack[i] is the response; domain i+1 is never released
  // before domain i has answered, and a missing answer ends in ERR.
  always_ff @(posedge osc_ck or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      dom_rstb_q <= '0;
      seq_busy_q <= 1'b0;
      seq_done_q <= 1'b0;
      ack_err_q  <= 1'b0;
      err_dom_q  <= '0;
    end else begin
      if (err_clr) ack_err_q <= 1'b0;
      if (!pwup_filt && state_q != S_IDLE) begin
        // Power loss overrides everything but keeps the error record.
        state_q    <= S_IDLE;
        idx_q      <= '0;
        cnt_q      <= '0;
        dom_rstb_q <= '0;
        seq_busy_q <= 1'b0;
        seq_done_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (pwup_filt && por_timed_out && !ack_err_q) begin
              state_q    <= S_GAP;
              gap_q      <= cfg_gap;
              idx_q      <= '0;
              cnt_q      <= '0;
              seq_busy_q <= 1'b1;
            end
          end
          S_GAP: begin
            if (cnt_q == gap_ext) begin
              dom_rstb_q <= dom_rstb_q | idx_onehot;
              cnt_q      <= '0;
              state_q    <= S_ACK;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          S_ACK: begin
            if (ack_cur) begin
              if (idx_q == IDX_LAST) begin
                state_q    <= S_DONE;
                seq_busy_q <= 1'b0;
                seq_done_q <= 1'b1;
              end else begin
                idx_q   <= idx_q + 3'd1;
                cnt_q   <= '0;
                state_q <= S_GAP;
              end
            end else if (cnt_q == ACK_LAST) begin
              state_q    <= S_ERR;
              ack_err_q  <= 1'b1;
              err_dom_q  <= idx_q;
              dom_rstb_q <= '0;
              seq_busy_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          S_DONE: begin
            dom_rstb_q <= '1;
          end
          S_ERR: begin
            if (err_clr) state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign dom_rstb  = dom_rstb_q;
  assign seq_busy  = seq_busy_q;
  assign seq_done  = seq_done_q;
  assign ack_err   = ack_err_q;
  assign err_dom   = err_dom_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_por_rst_seq.sv
// Bench for por_rst_seq: directed stimulus pushes timestamped expected output
// changes into a queue; a negedge monitor pops one per observed change.
module tb_por_rst_seq;

  localparam int N_DOM  = 4;
  localparam int GAP_W  = 8;
  localparam int ACK_TO = 255;
  localparam int W      = 42;

  logic             osc_ck = 1'b0;
  logic             rst = 1'b0;
  logic             pwup_filt = 1'b0;
  logic             por_timed_out = 1'b0;
  logic             err_clr = 1'b0;
  logic [GAP_W-1:0] cfg_gap = '0;
  logic [N_DOM-1:0] ack_hold = '0;
  logic [N_DOM-1:0] ack_manual = '0;
  logic [N_DOM-1:0] dom_ack;
  logic [N_DOM-1:0] dom_rstb;
  logic             seq_busy, seq_done, ack_err;
  logic [2:0]       err_dom, dbg_state;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [9:0]   prev_obs = '0;

  por_rst_seq #(.N_DOM(N_DOM), .GAP_W(GAP_W), .ACK_TO(ACK_TO)) dut (
    .osc_ck(osc_ck), .rst(rst), .pwup_filt(pwup_filt),
    .por_timed_out(por_timed_out), .cfg_gap(cfg_gap), .dom_ack(dom_ack),
    .err_clr(err_clr), .dom_rstb(dom_rstb), .seq_busy(seq_busy),
    .seq_done(seq_done), .ack_err(ack_err), .err_dom(err_dom),
    .dbg_state(dbg_state)
  );

  // Each domain acknowledges its own release unless the bench overrides it.
  assign dom_ack = (ack_hold & ack_manual) | (~ack_hold & dom_rstb);

  // ---------------- clock / reset ----------------
  always #5 osc_ck = ~osc_ck;
  always @(posedge osc_ck) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge osc_ck) begin
    logic [9:0]   o;
    logic [W-1:0] got;
    logic [W-1:0] ex;
    o = {seq_busy, seq_done, ack_err, err_dom, dom_rstb};
    if (o !== prev_obs) begin
      got = {cyc, o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event: unexpected change at cyc=%0d obs=%b, required no change", cyc, o);
      end else begin
        ex = exp_q.pop_front();
        if (got !== ex)  begin
          errors++;
          $display("FAIL event: got cyc=%0d obs=%b, required cyc=%0d obs=%b",
                   got[41:10], got[9:0], ex[41:10], ex[9:0]);
        end
      end
    end
    prev_obs = o;
  end

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [9:0] mk(input logic b, input logic d, input logic e,
                                    input logic [2:0] ed, input logic [3:0] r);
    return {b, d, e, ed, r};
  endfunction

  task automatic push(input int unsigned c, input logic [9:0] o);
    exp_q.push_back({c, o});
  endtask

  // s = IDLE-exit edge; ack tied to release, so spacing is g+1 (gap) + 3 (sync+act).
  task automatic push_seq(input int unsigned s, input int unsigned g, input logic [2:0] ed);
    int unsigned r;
    push(s, mk(1'b1, 1'b0, 1'b0, ed, 4'b0000));
    r = s + g + 1;
    push(r, mk(1'b1, 1'b0, 1'b0, ed, 4'b0001));
    r = r + g + 4;
    push(r, mk(1'b1, 1'b0, 1'b0, ed, 4'b0011));
    r = r + g + 4;
    push(r, mk(1'b1, 1'b0, 1'b0, ed, 4'b0111));
    r = r + g + 4;
    push(r, mk(1'b1, 1'b0, 1'b0, ed, 4'b1111));
    push(r + 3, mk(1'b0, 1'b1, 1'b0, ed, 4'b1111));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge osc_ck);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d events pending after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) @(negedge osc_ck);
  endtask

  task automatic abort_from_done(input logic [2:0] ed);
    push(cyc + 1, mk(1'b0, 1'b0, 1'b0, ed, 4'b0000));
    pwup_filt = 1'b0;
    drain("abort", 10);
    @(negedge osc_ck);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int unsigned t;
    #1 rst = 1'b1;
    #2;
    check("rst_dom_rstb", 32'(dom_rstb), 0);
    check("rst_seq_busy", 32'(seq_busy), 0);
    check("rst_seq_done", 32'(seq_done), 0);
    check("rst_ack_err", 32'(ack_err), 0);
    check("rst_err_dom", 32'(err_dom), 0);
    check("rst_state", 32'(dbg_state), 0);
    repeat (2) @(negedge osc_ck);
    rst = 1'b0;
    pwup_filt = 1'b1;
    cfg_gap = 8'd3;
    repeat (3) @(negedge osc_ck);
    check("idle_wait_por", 32'(dbg_state), 0);

    // Nominal sequence, gap 3.
    t = cyc;
    push_seq(t + 1, 3, 3'd0);
    por_timed_out = 1'b1;
    drain("nominal", 100);
    check("nominal_busy", 32'(seq_busy), 0);
    check("nominal_done", 32'(seq_done), 1);
    por_timed_out = 1'b0;
    repeat (5) @(negedge osc_ck);
    check("done_ignores_por_fall", 32'(dbg_state), 3);

    // Gap zero; a mid-sequence cfg_gap change must not alter spacing.
    por_timed_out = 1'b1;
    abort_from_done(3'd0);
    t = cyc;
    cfg_gap = 8'd0;
    pwup_filt = 1'b1;
    push_seq(t + 1, 0, 3'd0);
    repeat (3) @(negedge osc_ck);
    cfg_gap = 8'd200;
    drain("gap_zero", 100);

    // Acknowledge timeout on domain 2.
    abort_from_done(3'd0);
    cfg_gap = 8'd3;
    ack_hold = 4'b0100;
    ack_manual = 4'b0000;
    t = cyc;
    pwup_filt = 1'b1;
    push(t + 1,  mk(1'b1, 1'b0, 1'b0, 3'd0, 4'b0000));
    push(t + 5,  mk(1'b1, 1'b0, 1'b0, 3'd0, 4'b0001));
    push(t + 12, mk(1'b1, 1'b0, 1'b0, 3'd0, 4'b0011));
    push(t + 19, mk(1'b1, 1'b0, 1'b0, 3'd0, 4'b0111));
    push(t + 19 + ACK_TO, mk(1'b0, 1'b0, 1'b1, 3'd2, 4'b0000));
    drain("timeout", 400);
    repeat (20) @(negedge osc_ck);
    check("err_state_held", 32'(dbg_state), 4);
    check("err_ack_err", 32'(ack_err), 1);
    check("err_err_dom", 32'(err_dom), 2);
    ack_hold = 4'b0000;
    t = cyc;
    err_clr = 1'b1;
    push(t + 1, mk(1'b0, 1'b0, 1'b0, 3'd2, 4'b0000));
    push_seq(t + 2, 3, 3'd2);
    @(negedge osc_ck);
    err_clr = 1'b0;
    drain("replay_after_clr", 100);

    // Ack on domain 1 reaches the FSM exactly on the timeout edge.
    abort_from_done(3'd2);
    ack_hold = 4'b0010;
    ack_manual = 4'b0000;
    t = cyc;
    pwup_filt = 1'b1;
    push(t + 1,   mk(1'b1, 1'b0, 1'b0, 3'd2, 4'b0000));
    push(t + 5,   mk(1'b1, 1'b0, 1'b0, 3'd2, 4'b0001));
    push(t + 12,  mk(1'b1, 1'b0, 1'b0, 3'd2, 4'b0011));
    push(t + 271, mk(1'b1, 1'b0, 1'b0, 3'd2, 4'b0111));
    push(t + 278, mk(1'b1, 1'b0, 1'b0, 3'd2, 4'b1111));
    push(t + 281, mk(1'b0, 1'b1, 1'b0, 3'd2, 4'b1111));
    wait_until(t + 264);
    ack_manual = 4'b0010;
    drain("ack_on_timeout_edge", 100);
    ack_hold = 4'b0000;

    // Abort while waiting for domain 1's ack, then restart from domain 0.
    abort_from_done(3'd2);
    t = cyc;
    pwup_filt = 1'b1;
    push(t + 1,  mk(1'b1, 1'b0, 1'b0, 3'd2, 4'b0000));
    push(t + 5,  mk(1'b1, 1'b0, 1'b0, 3'd2, 4'b0001));
    push(t + 12, mk(1'b1, 1'b0, 1'b0, 3'd2, 4'b0011));
    push(t + 14, mk(1'b0, 1'b0, 1'b0, 3'd2, 4'b0000));
    wait_until(t + 13);
    pwup_filt = 1'b0;
    drain("abort_in_ack", 50);
    check("abort_state_idle", 32'(dbg_state), 0);
    @(negedge osc_ck);
    t = cyc;
    pwup_filt = 1'b1;
    push_seq(t + 1, 3, 3'd2);
    drain("restart_after_abort", 100);

    // Asynchronous reset in the middle of GAP.
    abort_from_done(3'd2);
    t = cyc;
    pwup_filt = 1'b1;
    push(t + 1, mk(1'b1, 1'b0, 1'b0, 3'd2, 4'b0000));
    repeat (2) @(negedge osc_ck);
    push(t + 3, mk(1'b0, 1'b0, 1'b0, 3'd0, 4'b0000));
    #2 rst = 1'b1;
    #1;
    check("async_rst_dom_rstb", 32'(dom_rstb), 0);
    check("async_rst_busy", 32'(seq_busy), 0);
    check("async_rst_err_dom", 32'(err_dom), 0);
    check("async_rst_state", 32'(dbg_state), 0);
    @(negedge osc_ck);
    @(negedge osc_ck);
    por_timed_out = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge osc_ck);
    check("post_rst_idle", 32'(dbg_state), 0);
    t = cyc;
    por_timed_out = 1'b1;
    push_seq(t + 1, 3, 3'd0);
    drain("post_rst_sequence", 100);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
